dict_word_packer: RTL
=====================

// Module: dict_word_packer
// PURPOSE
//  Initiator side of the Dictionary request interface. Packs a stream of recognised letters into the
//  120-bit word format: 15 slots x 8 bits, slot 0 = bits[7:0] = first letter, code 1..26 = a..z, 0 = empty.
//  On commit it pulses start, holds the word while the lookup runs, and waits for finish.
//  It then captures the corrected word and presents it downstream until it is accepted.
// PARAMETERS
//  MAX_LEN   15      letter slots; word width = 8*MAX_LEN
//  TIMEOUT   500000  WAIT-state cycle limit (used only with DICT_TIMEOUT_EN)
// PORTS
//  i_clk           in   1     clock, all logic on rising edge
//  i_rst_n         in   1     synchronous reset, ACTIVE-HIGH (name kept per codebase)
//  i_char_valid    in   1     letter offered
//  i_char          in   8     letter code
//  o_char_ready    out  1     letter/backspace/commit accepted this cycle
//  i_backspace     in   1     remove last letter
//  i_commit        in   1     end of word, request lookup
//  o_dict_start    out  1     one-cycle start pulse to Dictionary
//  o_dict_word     out  120   packed word to Dictionary
//  i_dict_finish   in   1     Dictionary done
//  i_dict_word     in   120   corrected word from Dictionary
//  o_word_valid    out  1     corrected word available
//  i_out_ready     in   1     downstream accepts o_word
//  o_word          out  120   corrected word
//  o_len           out  4     letters currently buffered
//  o_overflow      out  1     sticky: letter dropped because buffer was full
//  o_timeout       out  1     o_word is the raw word because the lookup timed out
//  o_state         out  3     IDLE=0 COLLECT=1 REQ=2 WAIT=3 DONE=4
// BEHAVIOUR
//  Reset: state IDLE; buffer, o_word and o_len cleared; all single-bit outputs 0.
//  o_char_ready = state in {IDLE, COLLECT}. Inputs are ignored in all other states.
//  Per accepted cycle, apply in order: backspace, else letter; then evaluate commit on the updated buffer.
//    backspace: if len>0, clear slot len-1 and len--; if len==0, no effect. A letter in the same cycle is dropped.
//    letter: codes 0 or >26 dropped silently. If len==MAX_LEN, letter dropped and o_overflow set.
//      Otherwise write slot len and len++.
//    commit: if len==0, ignored. Otherwise go to REQ.
//  State transitions:
//    IDLE->COLLECT on the first stored letter.
//    COLLECT->IDLE when len returns to 0 via backspace.
//    REQ lasts 1 cycle with o_dict_start=1, then WAIT. Commit in cycle t gives start in cycle t+1.
//    In WAIT: i_dict_finish=1 latches i_dict_word into o_word and moves to DONE (o_word_valid=1 next cycle).
//      i_dict_finish is sampled only in WAIT.
//    In DONE: o_word_valid is held until i_out_ready=1. Then clear buffer, len, o_overflow and o_timeout,
//      and go to IDLE.
//  o_dict_word = buffer. It is stable from REQ until exit from WAIT. Unused slots are 0.
//  Reset asserted in any state (incl. WAIT) aborts immediately to the reset values. The pending lookup is
//  abandoned and a later i_dict_finish is ignored in IDLE.
// CONFIGURATION
//  DICT_TIMEOUT_EN defined:
//    A cycle counter of width $clog2(TIMEOUT+1) starts at 0 on entry to WAIT.
//    If TIMEOUT cycles pass without finish: o_word <= buffer, o_timeout=1, go to DONE.
//    If finish arrives on the terminal cycle, finish wins.
//  DICT_TIMEOUT_EN undefined: WAIT holds indefinitely; o_timeout tied 0.
// TESTING
//  1. Letters 7,1,12,12,5,18,25 + commit -> o_dict_word[55:0]=56'h19_12_05_0C_0C_01_07, upper bits 0,
//     o_dict_start a single pulse the cycle after commit.
//  2. Dictionary returns finish after 10 cycles with word X -> o_word=X and o_word_valid held;
//     after i_out_ready=1 -> IDLE, o_len=0.
//  3. 16 letters then commit -> 15 stored, o_overflow=1, slot 14 = 15th letter; overflow clears after output.
//  4. Backspace with len=0 -> no change; 'a','b' then backspace+'c' in one cycle -> o_len=1, word[7:0]=8'h01.
//  5. Commit with empty buffer -> no start. Letter+commit in one cycle -> letter included, start next cycle.
//  6. Reset during WAIT, then a late finish -> IDLE, o_word_valid stays 0.
//     With DICT_TIMEOUT_EN and TIMEOUT=8: no finish -> raw word returned, o_timeout=1.

Source files
------------

// File: rtl/dict_word_packer.sv
// rtl/dict_word_packer.sv - letter-to-word packer, initiator side of the Dictionary request interface
//
// Packs accepted letter codes (1..26 = a..z) into a MAX_LEN x 8-bit word
// (slot 0 = bits[7:0] = first letter, unused slots 0). On commit it issues a
// one-cycle start, holds the word during the lookup, captures the corrected
// word on finish and presents it downstream until accepted.
//
// Optional feature macro: DICT_TIMEOUT_EN
//   defined   - WAIT gives up after TIMEOUT cycles and returns the raw word
//               with o_timeout=1
//   undefined - WAIT holds indefinitely, o_timeout is 0
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst_n        synchronous reset, active-high
//   i_char_valid   letter offered
//   i_char         letter code
//   o_char_ready   letter/backspace/commit accepted this cycle
//   i_backspace    remove last letter
//   i_commit       end of word, request lookup
//   o_dict_start   one-cycle start pulse to Dictionary
//   o_dict_word    packed word to Dictionary
//   i_dict_finish  Dictionary done
//   i_dict_word    corrected word from Dictionary
//   o_word_valid   corrected word available
//   i_out_ready    downstream accepts o_word
//   o_word         corrected word
//   o_len          letters currently buffered
//   o_overflow     sticky: letter dropped because buffer was full
//   o_timeout      o_word is the raw word because the lookup timed out
//   o_state        IDLE=0 COLLECT=1 REQ=2 WAIT=3 DONE=4
module dict_word_packer #(
  parameter int MAX_LEN = 15,
  parameter int TIMEOUT = 500000
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_char_valid,
  input  logic [7:0]             i_char,
  output logic                   o_char_ready,
  input  logic                   i_backspace,
  input  logic                   i_commit,
  output logic                   o_dict_start,
  output logic [8*MAX_LEN-1:0]   o_dict_word,
  input  logic                   i_dict_finish,
  input  logic [8*MAX_LEN-1:0]   i_dict_word,
  output logic                   o_word_valid,
  input  logic                   i_out_ready,
  output logic [8*MAX_LEN-1:0]   o_word,
  output logic [3:0]             o_len,
  output logic                   o_overflow,
  output logic                   o_timeout,
  output logic [2:0]             o_state
);

  localparam int W     = 8 * MAX_LEN;
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

`ifdef DICT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_REQ     = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]       state_q;
  logic [W-1:0]     buf_q;
  logic [LEN_W-1:0] len_q;
  logic [W-1:0]     word_q;
  logic             ovf_q;
  logic             to_q;
  logic [CNT_W-1:0] cnt_q;

  // Buffer update for an accepted cycle: backspace has priority over a
  // letter; commit is then judged on the updated length.
  logic [W-1:0]     buf_n;
  logic [LEN_W-1:0] len_n;
  logic             ovf_set;
  logic             letter_ok;
  int               slot;

  always_comb begin
    buf_n     = buf_q;
    len_n     = len_q;
    ovf_set   = 1'b0;
    slot      = 0;
    letter_ok = (i_char >= 8'd1) && (i_char <= 8'd26);
    if (i_backspace) begin
      if (len_q != '0) begin
        slot = int'(len_q) - 1;
        buf_n[slot*8 +: 8] = 8'h00;
        len_n = len_q - 1'b1;
      end
    end else if (i_char_valid && letter_ok) begin
      if (len_q == LEN_W'(MAX_LEN)) begin
        ovf_set = 1'b1;
      end else begin
        slot = int'(len_q);
        buf_n[slot*8 +: 8] = i_char;
        len_n = len_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      len_q   <= '0;
      word_q  <= '0;
      ovf_q   <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_COLLECT: begin
          buf_q <= buf_n;
          len_q <= len_n;
          if (ovf_set) ovf_q <= 1'b1;
          if (len_n == '0)   state_q <= S_IDLE;
          else if (i_commit) state_q <= S_REQ;
          else               state_q <= S_COLLECT;
        end
        S_REQ: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // Finish on the terminal count still wins over the timeout.
          if (i_dict_finish) begin
            word_q  <= i_dict_word;
            state_q <= S_DONE;
          end else if (TO_EN && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
            word_q  <= buf_q;
            to_q    <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          if (i_out_ready) begin
            buf_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
            to_q    <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_char_ready = (state_q == S_IDLE) || (state_q == S_COLLECT);
  assign o_dict_start = (state_q == S_REQ);
  assign o_word_valid = (state_q == S_DONE);
  assign o_dict_word  = buf_q;
  assign o_word       = word_q;
  assign o_len        = 4'(len_q);
  assign o_overflow   = ovf_q;
  assign o_timeout    = TO_EN ? to_q : 1'b0;
  assign o_state      = state_q;

endmodule
